// File: rtl/fft_bin_serializer.sv
// fft_bin_serializer: captures sixteen parallel FFT bins into a two-frame
// ping-pong buffer and replays them one bin per cycle over valid/ready.
module fft_bin_serializer #(
   parameter int unsigned BIN_W = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_fft_valid,
   input  logic [BIN_W-1:0] i_fft_d0,
   input  logic [BIN_W-1:0] i_fft_d1,
   input  logic [BIN_W-1:0] i_fft_d2,
   input  logic [BIN_W-1:0] i_fft_d3,
   input  logic [BIN_W-1:0] i_fft_d4,
   input  logic [BIN_W-1:0] i_fft_d5,
   input  logic [BIN_W-1:0] i_fft_d6,
   input  logic [BIN_W-1:0] i_fft_d7,
   input  logic [BIN_W-1:0] i_fft_d8,
   input  logic [BIN_W-1:0] i_fft_d9,
   input  logic [BIN_W-1:0] i_fft_d10,
   input  logic [BIN_W-1:0] i_fft_d11,
   input  logic [BIN_W-1:0] i_fft_d12,
   input  logic [BIN_W-1:0] i_fft_d13,
   input  logic [BIN_W-1:0] i_fft_d14,
   input  logic [BIN_W-1:0] i_fft_d15,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [BIN_W-1:0] o_out_data,
   output logic [3:0]       o_out_idx,
   output logic             o_out_last,
   output logic             o_overflow,
   output logic [CNT_W-1:0] o_frames_out,
   output logic [CNT_W-1:0] o_frames_dropped
);

   // Frame storage; contents are don't-care until the matching full flag is set.
   logic [BIN_W-1:0] r_buf [2][16];

   logic [1:0]       r_full;
   logic             r_wp;
   logic             r_rp;
   logic [3:0]       r_rd_idx;
   logic             r_overflow;
   logic [CNT_W-1:0] r_frames_out;
   logic [CNT_W-1:0] r_frames_dropped;

   logic [BIN_W-1:0] w_fft_d [16];
   logic             w_xfer;
   logic             w_release;
   logic             w_capture;
   logic             w_drop;
   logic [1:0]       w_full_d;

   assign w_fft_d[0]  = i_fft_d0;
   assign w_fft_d[1]  = i_fft_d1;
   assign w_fft_d[2]  = i_fft_d2;
   assign w_fft_d[3]  = i_fft_d3;
   assign w_fft_d[4]  = i_fft_d4;
   assign w_fft_d[5]  = i_fft_d5;
   assign w_fft_d[6]  = i_fft_d6;
   assign w_fft_d[7]  = i_fft_d7;
   assign w_fft_d[8]  = i_fft_d8;
   assign w_fft_d[9]  = i_fft_d9;
   assign w_fft_d[10] = i_fft_d10;
   assign w_fft_d[11] = i_fft_d11;
   assign w_fft_d[12] = i_fft_d12;
   assign w_fft_d[13] = i_fft_d13;
   assign w_fft_d[14] = i_fft_d14;
   assign w_fft_d[15] = i_fft_d15;

   // Capture/drop looks only at the pre-edge full flags, so a buffer released
   // on the same edge is never reused until the following cycle.
   assign w_xfer    = r_full[r_rp] & i_out_ready;
   assign w_release = w_xfer & (r_rd_idx == 4'd15);
   assign w_capture = i_fft_valid & ~r_full[r_wp];
   assign w_drop    = i_fft_valid & r_full[r_wp];

   // Next-state full flags: release and capture always target different buffers.
   always_comb begin
      w_full_d = r_full;
      if (w_release) begin
         w_full_d[r_rp] = 1'b0;
      end
      if (w_capture) begin
         w_full_d[r_wp] = 1'b1;
      end
   end

   // Write all sixteen bins into the buffer selected by the write pointer.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_capture) begin
         for (int k = 0; k < 16; k++) begin
            r_buf[r_wp][k] <= w_fft_d[k];
         end
      end
   end

   // Control state: pointers, read index, flags and counters.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_full           <= 2'b00;
         r_wp             <= 1'b0;
         r_rp             <= 1'b0;
         r_rd_idx         <= 4'd0;
         r_overflow       <= 1'b0;
         r_frames_out     <= '0;
         r_frames_dropped <= '0;
      end else begin
         r_full <= w_full_d;
         if (w_capture) begin
            r_wp <= ~r_wp;
         end
         if (w_drop) begin
            r_overflow       <= 1'b1;
            r_frames_dropped <= r_frames_dropped + CNT_W'(1);
         end
         if (w_release) begin
            r_rd_idx     <= 4'd0;
            r_rp         <= ~r_rp;
            r_frames_out <= r_frames_out + CNT_W'(1);
         end else if (w_xfer) begin
            r_rd_idx <= r_rd_idx + 4'd1;
         end
      end
   end

   // Output mux; data is masked to zero whenever nothing is being streamed.
   always_comb begin
      o_out_valid = r_full[r_rp];
      o_out_data  = r_full[r_rp] ? r_buf[r_rp][r_rd_idx] : '0;
      o_out_idx   = r_rd_idx;
      o_out_last  = (r_rd_idx == 4'd15);
   end

   assign o_overflow       = r_overflow;
   assign o_frames_out     = r_frames_out;
   assign o_frames_dropped = r_frames_dropped;

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Directed self-checking bench for fft_bin_serializer.
module tb_fft_bin_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fft_valid;
   logic [31:0] d [16];
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_idx;
   logic        out_last;
   logic        overflow;
   logic [7:0]  frames_out;
   logic [7:0]  frames_dropped;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fft_bin_serializer #(.BIN_W(32), .CNT_W(8)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_fft_valid      (fft_valid),
      .i_fft_d0         (d[0]),
      .i_fft_d1         (d[1]),
      .i_fft_d2         (d[2]),
      .i_fft_d3         (d[3]),
      .i_fft_d4         (d[4]),
      .i_fft_d5         (d[5]),
      .i_fft_d6         (d[6]),
      .i_fft_d7         (d[7]),
      .i_fft_d8         (d[8]),
      .i_fft_d9         (d[9]),
      .i_fft_d10        (d[10]),
      .i_fft_d11        (d[11]),
      .i_fft_d12        (d[12]),
      .i_fft_d13        (d[13]),
      .i_fft_d14        (d[14]),
      .i_fft_d15        (d[15]),
      .o_out_valid      (out_valid),
      .i_out_ready      (out_ready),
      .o_out_data       (out_data),
      .o_out_idx        (out_idx),
      .o_out_last       (out_last),
      .o_overflow       (overflow),
      .o_frames_out     (frames_out),
      .o_frames_dropped (frames_dropped)
   );

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One streamed bin: {valid, last, idx, data}.
   task automatic chk_bin(input string tag, input int idx, input logic [31:0] exp_data);
      logic [3:0] i4;
      i4 = 4'(idx);
      chk(tag, {26'd0, out_valid, out_last, out_idx, out_data},
          {26'd0, 1'b1, (idx == 15), i4, exp_data});
   endtask

   task automatic load(input logic [31:0] base, input logic [31:0] step);
      for (int k = 0; k < 16; k++) d[k] = base + step * 32'(k);
   endtask

   task automatic pulse();
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Stream a full frame of base+step*k with out_ready held high.
   task automatic stream(input string tag, input logic [31:0] base, input logic [31:0] step);
      for (int k = 0; k < 16; k++) begin
         chk_bin(tag, k, base + step * 32'(k));
         tick();
      end
   endtask

   initial begin
      rst       = 1'b1;
      fft_valid = 1'b0;
      out_ready = 1'b0;
      load(32'h0, 32'h0);
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_idx", 64'(out_idx), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_fout", 64'(frames_out), 64'd0);
      chk("rst_fdrop", 64'(frames_dropped), 64'd0);

      // Single frame: bin K = {0x0100*K, 0xFF00+K}
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         d[k] = {16'(16'h0100 * k), 16'(16'hFF00 + k)};
      end
      pulse();
      for (int k = 0; k < 16; k++) begin
         chk_bin("single", k, {16'(16'h0100 * k), 16'(16'hFF00 + k)});
         tick();
      end
      chk("single_idle", 64'(out_valid), 64'd0);
      chk("single_fout", 64'(frames_out), 64'd1);

      // FAS rate: a new frame every 16 cycles, captured on the bin-15 edge
      do_reset();
      out_ready = 1'b1;
      load(32'h0, 32'h0);
      pulse();
      for (int f = 0; f < 64; f++) begin
         for (int j = 0; j < 16; j++) begin
            chk_bin("fas", j, {16'(f), 16'(f)});
            if (j == 15 && f < 63) begin
               load({16'(f + 1), 16'(f + 1)}, 32'h0);
               fft_valid = 1'b1;
            end
            tick();
            fft_valid = 1'b0;
         end
      end
      chk("fas_idle", 64'(out_valid), 64'd0);
      chk("fas_fout", 64'(frames_out), 64'd64);
      chk("fas_fdrop", 64'(frames_dropped), 64'd0);
      chk("fas_ovf", 64'(overflow), 64'd0);

      // Backpressure: ready alternates 0,1 so each bin stalls one cycle
      do_reset();
      load(32'h1000_2000, 32'h0001_0001);
      out_ready = 1'b0;
      pulse();
      for (int c = 0; c < 32; c++) begin
         out_ready = (c % 2) == 1;
         chk_bin("bp", c / 2, 32'h1000_2000 + 32'h0001_0001 * 32'(c / 2));
         tick();
      end
      out_ready = 1'b0;
      chk("bp_idle", 64'(out_valid), 64'd0);
      chk("bp_fout", 64'(frames_out), 64'd1);

      // Overflow: three frames two cycles apart with the consumer stalled
      do_reset();
      out_ready = 1'b0;
      load(32'hA000_0000, 32'h1);
      pulse();
      tick();
      load(32'hB000_0000, 32'h1);
      pulse();
      tick();
      load(32'hC000_0000, 32'h1);
      pulse();
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_fdrop", 64'(frames_dropped), 64'd1);
      chk("ovf_fout", 64'(frames_out), 64'd0);
      chk_bin("ovf_hold", 0, 32'hA000_0000);
      out_ready = 1'b1;
      stream("ovf_a", 32'hA000_0000, 32'h1);
      stream("ovf_b", 32'hB000_0000, 32'h1);
      chk("ovf_idle", 64'(out_valid), 64'd0);
      chk("ovf_fout2", 64'(frames_out), 64'd2);

      // Simultaneous release and capture with both buffers full: drop
      do_reset();
      out_ready = 1'b0;
      load(32'h1111_0000, 32'h10);
      pulse();
      load(32'h2222_0000, 32'h10);
      pulse();
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         chk_bin("sim_a", k, 32'h1111_0000 + 32'h10 * 32'(k));
         if (k == 15) begin
            load(32'h3333_0000, 32'h10);
            fft_valid = 1'b1;
         end
         tick();
         fft_valid = 1'b0;
      end
      chk("sim_fdrop", 64'(frames_dropped), 64'd1);
      chk("sim_ovf", 64'(overflow), 64'd1);
      stream("sim_b", 32'h2222_0000, 32'h10);
      chk("sim_idle", 64'(out_valid), 64'd0);
      chk("sim_fout", 64'(frames_out), 64'd2);

      // Reset mid-stream at bin 7 with the other buffer full; counters are non-zero here
      out_ready = 1'b0;
      load(32'h4444_0000, 32'h3);
      pulse();
      load(32'h5555_0000, 32'h3);
      pulse();
      out_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         chk_bin("mid_a", k, 32'h4444_0000 + 32'h3 * 32'(k));
         tick();
      end
      chk_bin("mid_b7", 7, 32'h4444_0007 + 32'h0000_000E);
      rst       = 1'b1;
      fft_valid = 1'b1;
      load(32'h6666_0000, 32'h1);
      tick();
      rst       = 1'b0;
      fft_valid = 1'b0;
      chk("mid_valid", 64'(out_valid), 64'd0);
      chk("mid_idx", 64'(out_idx), 64'd0);
      chk("mid_fout", 64'(frames_out), 64'd0);
      chk("mid_fdrop", 64'(frames_dropped), 64'd0);
      chk("mid_ovf", 64'(overflow), 64'd0);
      tick();
      chk("mid_ignored", 64'(out_valid), 64'd0);
      load(32'h7777_0000, 32'h5);
      pulse();
      stream("mid_new", 32'h7777_0000, 32'h5);
      chk("mid_idle", 64'(out_valid), 64'd0);
      chk("mid_fout2", 64'(frames_out), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
